// File: rtl/reg_wb_pkg.sv
// Shared types and default sizing for the register-bank write-back controller.
package reg_wb_pkg;

  // Default number of queued load results
  localparam int WB_DEPTH        = 4;
  // Default number of cycles a queued load may wait behind ALU traffic
  localparam int WB_STARVE_LIMIT = 8;

  // Arbitration mode: ALU has priority (NORMAL) or the queue is being emptied (DRAIN)
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } wb_state_t;

  // One pending register-bank write
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending load results. The head entry is visible combinationally
// so the controller can register it straight into the write port on a pop.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  wb_req_t       mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  // Overflow and underflow are blocked here as well, so a misbehaving caller
  // cannot corrupt the pointers.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count_reg == FULL_COUNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-bank write-back arbiter: single-cycle ALU results have priority,
// load results queue in a FIFO and are drained when the queue fills or a
// queued result has waited too long.
module reg_wb_ctrl
  import reg_wb_pkg::*;
#(
  parameter int DEPTH        = WB_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_rd,
  input  logic [31:0]            alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [4:0]             mem_rd,
  input  logic [31:0]            mem_data,
  output logic                   mem_ready,
  output logic                   write_en,
  output logic [4:0]             w_addr,
  output logic [31:0]            write_data,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_SAT  = SW'(STARVE_LIMIT);

  wb_state_t     state_reg;
  logic [SW-1:0] starve_reg;
  logic [SW-1:0] starve_next;
  logic [CW-1:0] count;
  logic [CW-1:0] pend_next;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          alu_take;
  logic          sel_valid;
  wb_req_t       alu_req;
  wb_req_t       mem_req;
  wb_req_t       head;
  wb_req_t       sel_req;
  logic          write_en_reg;
  logic [4:0]    w_addr_reg;
  logic [31:0]   write_data_reg;

  // Handshakes depend only on registered state (and reset), never on the pop
  assign alu_ready = !reset && (state_reg == ST_NORMAL);
  assign mem_ready = !reset && !full;
  assign alu_take  = alu_valid && alu_ready;
  assign push      = mem_valid && mem_ready;
  // In NORMAL the queue is served only on cycles the ALU leaves free
  assign pop       = !reset && !empty && ((state_reg == ST_DRAIN) || !alu_valid);

  assign alu_req.rd   = alu_rd;
  assign alu_req.data = alu_data;
  assign mem_req.rd   = mem_rd;
  assign mem_req.data = mem_data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mem_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Next occupancy, starvation count and the selected write for this cycle
  always_comb begin
    pend_next = count;
    if (push && !pop) begin
      pend_next = count + CW'(1);
    end else if (!push && pop) begin
      pend_next = count - CW'(1);
    end

    starve_next = starve_reg;
    if (empty || pop) begin
      starve_next = '0;
    end else if (starve_reg != STARVE_SAT) begin
      starve_next = starve_reg + SW'(1);
    end

    sel_valid = alu_take || pop;
    sel_req   = alu_take ? alu_req : head;
  end

  // Mode FSM plus registered write port; x0 results are consumed silently
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_NORMAL;
      starve_reg     <= '0;
      write_en_reg   <= 1'b0;
      w_addr_reg     <= '0;
      write_data_reg <= '0;
    end else begin
      starve_reg <= starve_next;
      case (state_reg)
        ST_NORMAL: begin
          if ((pend_next == FULL_COUNT) || (starve_next == STARVE_SAT)) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pend_next == '0) begin
            state_reg <= ST_NORMAL;
          end
        end
        default: state_reg <= ST_NORMAL;
      endcase

      write_en_reg <= sel_valid && (sel_req.rd != 5'd0);
      if (sel_valid && (sel_req.rd != 5'd0)) begin
        w_addr_reg     <= sel_req.rd;
        write_data_reg <= sel_req.data;
      end
    end
  end

  assign write_en   = write_en_reg;
  assign w_addr     = w_addr_reg;
  assign write_data = write_data_reg;
  assign pending    = count;

endmodule
